// File: rtl/mac_pkg.sv
// Shared definitions for the multi-lane MAC array: FSM states, requantisation
// (round-half-up + signed saturation) and the parameter-legality check.
package mac_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Requantisation runs at a fixed wide width so one function serves any ACC_W/OUT_W.
  localparam int unsigned RS_W    = 128;
  localparam int unsigned RS_SH_W = 7;

  typedef struct packed {
    logic            sat;
    logic [RS_W-1:0] val;
  } rs_t;

  function automatic rs_t round_sat(input logic signed [RS_W-1:0]    acc,
                                    input logic        [RS_SH_W-1:0] sh,
                                    input int unsigned               out_w);
    logic signed [RS_W-1:0] bias;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    rs_t                    o;
    bias  = (sh == '0) ? '0 : (RS_W'(1) << (sh - 1'b1));
    r     = (acc + bias) >>> sh;
    hi    = (RS_W'(1) << (out_w - 1)) - RS_W'(1);
    lo    = ~hi;
    o.sat = (r > hi) || (r < lo);
    if (r > hi)      o.val = hi;
    else if (r < lo) o.val = lo;
    else             o.val = r;
    return o;
  endfunction

  function automatic bit params_ok(input int unsigned data_w,
                                   input int unsigned lanes,
                                   input int unsigned cnt_w,
                                   input int unsigned acc_w,
                                   input int unsigned out_w,
                                   input int unsigned shift_w);
    return (lanes >= 1) && (data_w >= 2) && (cnt_w >= 1) &&
           (acc_w >= 2 * data_w + cnt_w) && (acc_w < RS_W) &&
           (out_w >= 2) && (out_w <= acc_w) &&
           (shift_w >= 1) && (shift_w <= RS_SH_W);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed MAC lane: multiply, zero-skip accumulator enable, and
// requantisation of the next accumulator value.
module mac_lane
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 44,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     first,
  input  logic [SHIFT_W-1:0]       sh,
  input  logic signed [DATA_W-1:0] pixel,
  input  logic signed [DATA_W-1:0] kernel,
  output logic [OUT_W-1:0]         res,
  output logic                     sat
);

  logic signed [2*DATA_W-1:0] p_ext;
  logic signed [2*DATA_W-1:0] k_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_next;
  logic                       nz;
  rs_t                        rs;
  logic                       unused_hi;

  assign p_ext    = {{DATA_W{pixel[DATA_W-1]}}, pixel};
  assign k_ext    = {{DATA_W{kernel[DATA_W-1]}}, kernel};
  assign prod     = p_ext * k_ext;
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign nz       = (pixel != '0) && (kernel != '0);
  assign acc_next = first ? prod_ext : acc_q + prod_ext;

  // A zero operand leaves the register idle; the first beat must still load to drop the old window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (en && (first || nz)) begin
      acc_q <= acc_next;
    end
  end

  assign rs        = round_sat({{(RS_W-ACC_W){acc_next[ACC_W-1]}}, acc_next},
                               RS_SH_W'(sh), OUT_W);
  assign res       = rs.val[OUT_W-1:0];
  assign sat       = rs.sat;
  assign unused_hi = ^rs.val[RS_W-1:OUT_W];

endmodule

// File: rtl/mac_array.sv
// LANES parallel signed MAC lanes on one valid/ready stream; windowed
// accumulation, requantisation and a back-pressured result register.
module mac_array
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LANES   = 4,
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned ACC_W   = 44,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic [CNT_W-1:0]          cfg_len,
  input  logic [SHIFT_W-1:0]        cfg_shift,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   pixel_in,
  input  logic [LANES*DATA_W-1:0]   kernel_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_W-1:0]    out_data,
  output logic [LANES-1:0]          out_sat,
  output logic                      busy
);

  if (!params_ok(DATA_W, LANES, CNT_W, ACC_W, OUT_W, SHIFT_W)) begin : g_param_check
    $error("mac_array: illegal parameter set");
  end

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_next;
  logic [CNT_W-1:0]     len_q;
  logic [CNT_W-1:0]     len_eff;
  logic [SHIFT_W-1:0]   sh_q;
  logic [SHIFT_W-1:0]   sh_eff;
  logic                 first;
  logic                 accept;
  logic                 done;
  logic [LANES*OUT_W-1:0] lane_res;
  logic [LANES-1:0]     lane_sat;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !clr;
  assign first    = (state == IDLE);
  assign busy     = (state == ACC);

  // The first beat sees the live configuration so a 1-beat window completes on that same edge.
  assign len_eff  = first ? ((cfg_len == '0) ? CNT_W'(1) : cfg_len) : len_q;
  assign sh_eff   = first ? cfg_shift : sh_q;
  assign cnt_next = first ? CNT_W'(1) : cnt + 1'b1;
  assign done     = accept && (cnt_next == len_eff);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= CNT_W'(1);
      sh_q      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else begin
      if (clr) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (accept) begin
        if (first) begin
          len_q <= len_eff;
          sh_q  <= cfg_shift;
        end
        if (done) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          state <= ACC;
          cnt   <= cnt_next;
        end
      end
      if (done) begin
        out_valid <= 1'b1;
        out_data  <= lane_res;
        out_sat   <= lane_sat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    mac_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .OUT_W  (OUT_W),
      .SHIFT_W(SHIFT_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en    (accept),
      .first (first),
      .sh    (sh_eff),
      .pixel (pixel_in[gi*DATA_W +: DATA_W]),
      .kernel(kernel_in[gi*DATA_W +: DATA_W]),
      .res   (lane_res[gi*OUT_W +: OUT_W]),
      .sat   (lane_sat[gi])
    );
  end

endmodule

// File: tb/tb_mac_array.sv
// Self-checking bench for mac_array: directed scenarios plus randomized
// traffic against a window-sum reference model.
module tb_mac_array;

  localparam int L  = 4;
  localparam int DW = 16;
  localparam int OW = 16;

  logic            clk = 1'b0;
  logic            rst, clr, in_valid, out_ready;
  logic            in_ready, out_valid, busy;
  logic [11:0]     cfg_len;
  logic [4:0]      cfg_shift;
  logic [L*DW-1:0] pixel_in, kernel_in;
  logic [L*OW-1:0] out_data;
  logic [L-1:0]    out_sat;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: window sums as plain integers
  longint m_sum[L];
  int     m_od[L];
  bit     m_os[L];
  bit     m_ov, m_win;
  int     m_cnt, m_len, m_sh;

  mac_array #(
    .DATA_W(DW), .LANES(L), .CNT_W(12), .ACC_W(44), .OUT_W(OW), .SHIFT_W(5)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
    .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in), .kernel_in(kernel_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic longint lane_val(input logic [L*DW-1:0] bus, input int l);
    logic signed [DW-1:0] v;
    v = bus[l*DW +: DW];
    return longint'(v);
  endfunction

  function automatic void requant(input longint s, input int sh, output int r, output bit sat);
    longint v;
    v = (sh > 0) ? ((s + (longint'(1) << (sh - 1))) >>> sh) : s;
    if (v > 32767)       begin r = 32767;  sat = 1'b1; end
    else if (v < -32768) begin r = -32768; sat = 1'b1; end
    else                 begin r = int'(v); sat = 1'b0; end
  endfunction

  function automatic int rnd_op();
    int m;
    m = int'($urandom_range(0, 5));
    if (m == 0) return 0;
    if (m < 3)  return int'($urandom_range(0, 200)) - 100;
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic model_reset();
    m_ov = 1'b0; m_win = 1'b0; m_cnt = 0; m_len = 1; m_sh = 0;
    for (int l = 0; l < L; l++) begin m_sum[l] = 0; m_od[l] = 0; m_os[l] = 1'b0; end
  endtask

  task automatic set_lane(input int l, input int p, input int k);
    logic [DW-1:0] pv, kv;
    pv = DW'(p);
    kv = DW'(k);
    pixel_in[l*DW +: DW]  = pv;
    kernel_in[l*DW +: DW] = kv;
  endtask

  task automatic rand_lanes(input int from);
    for (int l = from; l < L; l++) set_lane(l, rnd_op(), rnd_op());
  endtask

  // One clock edge; the model consumes the inputs held across it.
  task automatic step();
    bit acc, done;
    @(posedge clk);
    acc  = in_valid && (!m_ov || out_ready) && !clr;
    done = 1'b0;
    if (clr) begin
      m_win = 1'b0; m_cnt = 0;
    end else if (acc) begin
      if (!m_win) begin
        m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
        m_sh  = int'(cfg_shift);
        m_cnt = 0;
        for (int l = 0; l < L; l++) m_sum[l] = 0;
      end
      for (int l = 0; l < L; l++) m_sum[l] += lane_val(pixel_in, l) * lane_val(kernel_in, l);
      m_cnt++;
      if (m_cnt == m_len) begin
        done = 1'b1; m_win = 1'b0; m_cnt = 0;
        for (int l = 0; l < L; l++) requant(m_sum[l], m_sh, m_od[l], m_os[l]);
      end else begin
        m_win = 1'b1;
      end
    end
    if (done) m_ov = 1'b1;
    else if (out_ready) m_ov = 1'b0;
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #3;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h expected 0", out_data); end
    n_tests++; if (out_sat !== '0) begin n_fail++; $display("FAIL rst_out_sat: got %b expected 0", out_sat); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    idle();
  endtask

  task automatic test_accumulate();
    int p[3] = '{2, 3, 4};
    int k[3] = '{5, 6, 7};
    cfg_len = 12'd3; cfg_shift = 5'd0; out_ready = 1'b1; in_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      set_lane(0, p[b], k[b]);
      set_lane(1, b + 1, -100); set_lane(2, -(b * 7), 300); set_lane(3, 1000, 1000);
      step();
      if (b < 2) begin
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++;
          $display("FAIL acc_mid beat %0d: got valid %b busy %b expected valid 0 busy 1", b, out_valid, busy); end
      end
    end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL acc_valid: got %b expected 1", out_valid); end
    n_tests++; if (out_data[15:0] !== 16'd56 || out_sat[0] !== 1'b0) begin n_fail++;
      $display("FAIL acc_lane0: got %0d sat %b expected 56 sat 0", $signed(out_data[15:0]), out_sat[0]); end
    for (int l = 1; l < L; l++) begin
      logic [OW-1:0] e;
      e = OW'(m_od[l]);
      n_tests++; if (out_data[l*OW +: OW] !== e || out_sat[l] !== m_os[l]) begin n_fail++;
        $display("FAIL acc_lane%0d: got %0d sat %b expected %0d sat %b", l, $signed(out_data[l*OW +: OW]), out_sat[l], $signed(e), m_os[l]); end
    end
    idle();
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL acc_pop: got valid %b busy %b expected 0 0", out_valid, busy); end
  endtask

  task automatic test_saturation();
    int p[3] = '{32767, -32768, -3};
    int k[3] = '{32767, 32767, 4};
    int e[3] = '{32767, -32768, -12};
    bit s[3] = '{1'b1, 1'b1, 1'b0};
    cfg_len = 12'd1; cfg_shift = 5'd0; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_lane(0, p[i], k[i]); rand_lanes(1);
      step();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid %0d: got %b expected 1", i, out_valid); end
      n_tests++; if (out_data[15:0] !== 16'(e[i]) || out_sat[0] !== s[i]) begin n_fail++;
        $display("FAIL sat_lane0 %0d: got %0d sat %b expected %0d sat %b", i, $signed(out_data[15:0]), out_sat[0], e[i], s[i]); end
    end
    idle();
  endtask

  task automatic test_rounding();
    int p[3] = '{24, 23, -24};
    int e[3] = '{2, 1, -1};
    cfg_len = 12'd1; cfg_shift = 5'd4; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_lane(0, p[i], 1); rand_lanes(1);
      step();
      n_tests++; if (out_data[15:0] !== 16'(e[i]) || out_sat[0] !== 1'b0) begin n_fail++;
        $display("FAIL round_lane0 %0d: got %0d sat %b expected %0d sat 0", i, $signed(out_data[15:0]), out_sat[0], e[i]); end
    end
    idle();
  endtask

  task automatic test_back_pressure();
    logic [L*OW-1:0] held;
    cfg_len = 12'd2; cfg_shift = 5'd10; out_ready = 1'b0; in_valid = 1'b1;
    rand_lanes(0); step();
    rand_lanes(0); step();
    n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++;
      $display("FAIL bp_first: got valid %b in_ready %b expected 1 0", out_valid, in_ready); end
    for (int l = 0; l < L; l++) held[l*OW +: OW] = OW'(m_od[l]);
    n_tests++; if (out_data !== held) begin n_fail++; $display("FAIL bp_first_data: got %h expected %h", out_data, held); end
    rand_lanes(0);
    for (int c = 0; c < 2; c++) begin
      step();
      n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b0 || out_data !== held) begin n_fail++;
        $display("FAIL bp_stall %0d: got in_ready %b valid %b busy %b data %h expected 0 1 0 %h", c, in_ready, out_valid, busy, out_data, held); end
    end
    out_ready = 1'b1; step();
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL bp_pop: got valid %b busy %b expected 0 1", out_valid, busy); end
    rand_lanes(0); out_ready = 1'b0; step();
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %b expected 1", out_valid); end
    for (int l = 0; l < L; l++) begin
      logic [OW-1:0] e;
      e = OW'(m_od[l]);
      n_tests++; if (out_data[l*OW +: OW] !== e || out_sat[l] !== m_os[l]) begin n_fail++;
        $display("FAIL bp_second lane %0d: got %0d sat %b expected %0d sat %b", l, $signed(out_data[l*OW +: OW]), out_sat[l], $signed(e), m_os[l]); end
    end
    idle();
  endtask

  task automatic test_zero_skip_clr();
    cfg_len = 12'd2; cfg_shift = 5'd0; out_ready = 1'b0; in_valid = 1'b1;
    set_lane(0, 0, 9); rand_lanes(1); step();
    set_lane(0, 5, 2); rand_lanes(1); step();
    n_tests++; if (out_valid !== 1'b1 || out_data[15:0] !== 16'd10) begin n_fail++;
      $display("FAIL zskip: got valid %b data %0d expected 1 10", out_valid, $signed(out_data[15:0])); end
    in_valid = 1'b0; clr = 1'b1; step(); clr = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_data[15:0] !== 16'd10) begin n_fail++;
      $display("FAIL clr_holds_out: got valid %b data %0d expected 1 10", out_valid, $signed(out_data[15:0])); end
    idle();
    cfg_len = 12'd3; in_valid = 1'b1;
    set_lane(0, 77, -5); rand_lanes(1); step();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_pre_busy: got %b expected 1", busy); end
    clr = 1'b1; step(); clr = 1'b0;
    n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++;
      $display("FAIL clr_flush: got busy %b valid %b expected 0 0", busy, out_valid); end
    for (int b = 0; b < 3; b++) begin
      set_lane(0, 1, 1); rand_lanes(1); step();
      if (b == 1) begin
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_early: got valid %b expected 0", out_valid); end
      end
    end
    n_tests++; if (out_valid !== 1'b1 || out_data[15:0] !== 16'd3) begin n_fail++;
      $display("FAIL clr_refill: got valid %b data %0d expected 1 3", out_valid, $signed(out_data[15:0])); end
    idle();
  endtask

  task automatic test_reset_mid();
    cfg_len = 12'd1; cfg_shift = 5'd0; out_ready = 1'b0; in_valid = 1'b1;
    rand_lanes(0); step();
    in_valid = 1'b0; #2; rst = 1'b0; model_reset(); #1;
    n_tests++; if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL rst_held: got valid %b data %h sat %b in_ready %b busy %b expected 0 0 0 1 0", out_valid, out_data, out_sat, in_ready, busy); end
    @(posedge clk); #1; rst = 1'b1;
    cfg_len = 12'd3; out_ready = 1'b1; in_valid = 1'b1;
    rand_lanes(0); step(); rand_lanes(0); step();
    in_valid = 1'b0; #2; rst = 1'b0; model_reset(); #1;
    n_tests++; if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid: got valid %b data %h sat %b in_ready %b busy %b expected 0 0 0 1 0", out_valid, out_data, out_sat, in_ready, busy); end
    @(posedge clk); #1; rst = 1'b1;
    cfg_len = 12'd1; in_valid = 1'b1;
    set_lane(0, 7, -6); rand_lanes(1); step();
    n_tests++; if (out_valid !== 1'b1 || out_data[15:0] !== 16'hFFD6) begin n_fail++;
      $display("FAIL rst_after: got valid %b data %0d expected 1 -42", out_valid, $signed(out_data[15:0])); end
    idle();
  endtask

  task automatic test_max_len();
    cfg_len = 12'd4095; cfg_shift = 5'd31; out_ready = 1'b1; in_valid = 1'b1;
    set_lane(0, -32768, -32768); set_lane(1, 32767, -32768);
    set_lane(2, 32767, 32767);   set_lane(3, 1234, -5);
    for (int i = 0; i < 4095; i++) begin
      step();
      if (i == 4093) begin
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++;
          $display("FAIL maxlen_pre: got valid %b busy %b expected 0 1", out_valid, busy); end
      end
    end
    n_tests++; if (out_valid !== 1'b1 || out_data[15:0] !== 16'd2048) begin n_fail++;
      $display("FAIL maxlen_lane0: got valid %b data %0d expected 1 2048", out_valid, $signed(out_data[15:0])); end
    for (int l = 1; l < L; l++) begin
      logic [OW-1:0] e;
      e = OW'(m_od[l]);
      n_tests++; if (out_data[l*OW +: OW] !== e || out_sat[l] !== m_os[l]) begin n_fail++;
        $display("FAIL maxlen lane %0d: got %0d sat %b expected %0d sat %b", l, $signed(out_data[l*OW +: OW]), out_sat[l], $signed(e), m_os[l]); end
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clr       = ($urandom_range(0, 31) == 0);
      cfg_len   = 12'($urandom_range(0, 5));
      cfg_shift = 5'($urandom_range(0, 23));
      rand_lanes(0);
      step();
      n_tests++; if (in_ready !== (!m_ov || out_ready) || out_valid !== m_ov || busy !== m_win) begin n_fail++;
        $display("FAIL rand_ctrl cycle %0d: got in_ready %b valid %b busy %b expected %b %b %b",
                 c, in_ready, out_valid, busy, (!m_ov || out_ready), m_ov, m_win); end
      if (m_ov) begin
        for (int l = 0; l < L; l++) begin
          logic [OW-1:0] e;
          e = OW'(m_od[l]);
          n_tests++; if (out_data[l*OW +: OW] !== e || out_sat[l] !== m_os[l]) begin n_fail++;
            $display("FAIL rand_data cycle %0d lane %0d: got %0d sat %b expected %0d sat %b",
                     c, l, $signed(out_data[l*OW +: OW]), out_sat[l], $signed(e), m_os[l]); end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_len = '0; cfg_shift = '0; pixel_in = '0; kernel_in = '0;
    model_reset();
    test_reset();
    test_accumulate();
    test_saturation();
    test_rounding();
    test_back_pressure();
    test_zero_skip_clr();
    test_reset_mid();
    test_max_len();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
